// File: rtl/i2c_ctrl_core_if.sv
// Byte-level handshake between the configuration sequencer and the I2C byte engine.
interface i2c_ctrl_core_if;
    logic       wr_req;
    logic       rd_req;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_done;
    logic       wr_done;

    // Sequencer side: supplies bytes and requests, consumes done pulses.
    modport master (
        output wr_req, rd_req, wr_data,
        input  rd_data, rd_done, wr_done
    );

    // Engine side.
    modport slave (
        input  wr_req, rd_req, wr_data,
        output rd_data, rd_done, wr_done
    );
endinterface

// File: rtl/i2c_ctrl_core.sv
// Single-master I2C byte engine: START, device/register address, write burst or
// repeated-START read burst, STOP. Each bit is four quarters of QTR clocks.
module i2c_ctrl_core #(
    parameter int unsigned SYS_CLK = 50_000_000,
    parameter int unsigned SCL_CLK = 400_000
) (
    input  logic           clk,
    input  logic           rst,
    i2c_ctrl_core_if.slave bus,
    output logic           i2c_scl,
    inout  wire            i2c_sda,
    output logic           is_out
);

    localparam int unsigned QTR   = SYS_CLK / (4 * SCL_CLK);
    localparam logic [15:0] QLAST = 16'(QTR - 1);

    typedef enum logic [7:0] {
        StIdle      = 8'h01,
        StWrStart   = 8'h02,
        StWrDevAddr = 8'h04,
        StWrRegAddr = 8'h08,
        StWrData    = 8'h10,
        StRdStart   = 8'h20,
        StRdData    = 8'h40,
        StStop      = 8'h80
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic        op_rd_q, op_rd_d;
    logic        addr_ph_q, addr_ph_d;   // RD_START: 0 = start bit, 1 = address byte
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        ack_q, ack_d;           // sampled slave ACK bit (1 = NACK)
    logic        nack_q, nack_d;         // master ACK bit for the current read byte
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        is_out_q, is_out_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic       sda_in;
    logic       qtr_end, bit_end, byte_end, q2_start, sending;
    logic [2:0] bidx;

    assign sda_in      = i2c_sda;
    assign i2c_sda     = is_out_q ? sda_q : 1'bz;
    assign i2c_scl     = scl_q;
    assign is_out      = is_out_q;
    assign bus.wr_done = wr_done_q;
    assign bus.rd_done = rd_done_q;
    assign bus.rd_data = rd_data_q;

    // Next-state logic; outputs are derived from next-state values so that the
    // registered pins line up exactly with the quarter counters.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        op_rd_d   = op_rd_q;
        addr_ph_d = addr_ph_q;
        dev_d     = dev_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        rd_data_d = rd_data_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        scl_d     = 1'b1;
        sda_d     = 1'b1;
        is_out_d  = 1'b1;
        bidx      = 3'd0;

        qtr_end  = (cnt_q == QLAST);
        bit_end  = qtr_end && (qtr_q == 2'd3);
        byte_end = bit_end && (bit_q == 4'd8);
        q2_start = (cnt_q == 16'd0) && (qtr_q == 2'd2);
        sending  = (state_q == StWrDevAddr) || (state_q == StWrRegAddr) ||
                   (state_q == StWrData) || ((state_q == StRdStart) && addr_ph_q);

        if (state_q == StIdle) begin
            cnt_d = '0;
            qtr_d = '0;
            bit_d = '0;
        end else begin
            cnt_d = qtr_end ? 16'd0 : cnt_q + 16'd1;
            if (qtr_end) qtr_d = qtr_q + 2'd1;
            if (bit_end) bit_d = (bit_q == 4'd8) ? 4'd0 : bit_q + 4'd1;
        end

        if (q2_start && sending && (bit_q == 4'd8)) ack_d = sda_in;
        if (q2_start && (state_q == StRdData) && (bit_q < 4'd8)) rx_d = {rx_q[6:0], sda_in};

        // Pulse lands on the last clk of an ACKed byte.
        if (sending && (bit_q == 4'd8) && (qtr_q == 2'd3) && (cnt_q == QLAST - 16'd1) && !ack_q)
            wr_done_d = 1'b1;

        // Read byte complete: publish it and fix the master ACK from rd_req now.
        if ((state_q == StRdData) && bit_end && (bit_q == 4'd7)) begin
            rd_data_d = rx_q;
            rd_done_d = 1'b1;
            nack_d    = ~bus.rd_req;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.wr_req || bus.rd_req) begin
                    state_d = StWrStart;
                    op_rd_d = ~bus.wr_req;
                end
            end
            StWrStart: begin
                if (bit_end) begin
                    dev_d   = bus.wr_data[7:1];
                    tx_d    = {bus.wr_data[7:1], 1'b0};
                    bit_d   = 4'd0;
                    state_d = StWrDevAddr;
                end
            end
            StWrDevAddr: begin
                if (byte_end) begin
                    state_d = ack_q ? StStop : StWrRegAddr;
                    tx_d    = bus.wr_data;
                end
            end
            StWrRegAddr: begin
                if (byte_end) begin
                    if (ack_q) begin
                        state_d = StStop;
                    end else if (op_rd_q) begin
                        state_d   = StRdStart;
                        addr_ph_d = 1'b0;
                    end else if (bus.wr_req) begin
                        state_d = StWrData;
                        tx_d    = bus.wr_data;
                    end else begin
                        state_d = StStop;
                    end
                end
            end
            StWrData: begin
                if (byte_end) begin
                    if (ack_q || !bus.wr_req) state_d = StStop;
                    else                      tx_d    = bus.wr_data;
                end
            end
            StRdStart: begin
                if (!addr_ph_q && bit_end) begin
                    addr_ph_d = 1'b1;
                    bit_d     = 4'd0;
                    tx_d      = {dev_q, 1'b1};
                end else if (addr_ph_q && byte_end) begin
                    state_d = ack_q ? StStop : StRdData;
                end
            end
            StRdData: begin
                if (byte_end && nack_q) state_d = StStop;
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    bit_d   = 4'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        unique case (state_d)
            StIdle: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
            StWrStart: begin
                scl_d = (qtr_d != 2'd3);
                sda_d = ~qtr_d[1];
            end
            StStop: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = qtr_d[1];
            end
            StRdData: begin
                scl_d = qtr_d[1];
                if (bit_d == 4'd8) begin
                    sda_d = nack_d;
                end else begin
                    is_out_d = 1'b0;
                end
            end
            StWrDevAddr, StWrRegAddr, StWrData, StRdStart: begin
                if ((state_d == StRdStart) && !addr_ph_d) begin
                    scl_d = (qtr_d != 2'd3);
                    sda_d = ~qtr_d[1];
                end else begin
                    scl_d = qtr_d[1];
                    if (bit_d == 4'd8) begin
                        is_out_d = 1'b0;
                    end else begin
                        bidx  = 3'd7 - bit_d[2:0];
                        sda_d = tx_d[bidx];
                    end
                end
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            op_rd_q   <= 1'b0;
            addr_ph_q <= 1'b0;
            dev_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            is_out_q  <= 1'b1;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            op_rd_q   <= op_rd_d;
            addr_ph_q <= addr_ph_d;
            dev_q     <= dev_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            is_out_q  <= is_out_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_i2c_ctrl_core.sv
// Directed bench for i2c_ctrl_core with a behavioural I2C slave on the pins.
module tb_i2c_ctrl_core;

    localparam int WDone   = 0;
    localparam int RDone   = 1;
    localparam int Idle    = 2;
    localparam int InWrDat = 3;
    localparam int Dut2Dev = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_ctrl_core_if bus ();
    i2c_ctrl_core_if bus2 ();

    wire  i2c_sda;
    wire  sda2;
    logic i2c_scl, is_out, scl2, is_out2;
    logic slv_sda = 1'b1;

    assign i2c_sda = is_out ? 1'bz : slv_sda;
    assign sda2    = is_out2 ? 1'bz : 1'b1;   // no slave on the second bus: always NACK

    i2c_ctrl_core dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda),
        .is_out  (is_out)
    );

    i2c_ctrl_core #(.SCL_CLK(100_000)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .i2c_scl (scl2),
        .i2c_sda (sda2),
        .is_out  (is_out2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor and slave state, all owned by one process.
    int         cyc = 0;
    int         wr_done_cnt = 0, rd_done_cnt = 0, stop_cnt = 0;
    int         scl_per = 0, scl2_per = 0, last_rise = 0, last_rise2 = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_scl2 = 1'b1, prev_stop = 1'b0;
    int         s_bit = -1, s_byte = 0;
    logic       s_rd = 1'b0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] got[$];
    logic       mack[$];
    int         nack_at = -1;
    logic [7:0] rd_vals[2];

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.wr_done === 1'b1) wr_done_cnt++;
        if (bus.rd_done === 1'b1) rd_done_cnt++;
        if (dut.state_q == 8'h80 && !prev_stop) stop_cnt++;
        prev_stop = (dut.state_q == 8'h80);
        if (i2c_scl === 1'b1 && prev_scl === 1'b0) begin
            scl_per   = cyc - last_rise;
            last_rise = cyc;
        end
        if (scl2 === 1'b1 && prev_scl2 === 1'b0) begin
            scl2_per   = cyc - last_rise2;
            last_rise2 = cyc;
        end
        if (prev_scl === 1'b1 && i2c_scl === 1'b1 && prev_sda === 1'b1 && i2c_sda === 1'b0) begin
            s_bit  = -1;
            s_byte = 0;
            s_rd   = 1'b0;
        end else if (prev_scl === 1'b0 && i2c_scl === 1'b1) begin
            if (s_rd && s_byte > 0) begin
                if (s_bit == 8) mack.push_back(i2c_sda);
            end else if (s_bit >= 0 && s_bit < 8) begin
                s_sh = {s_sh[6:0], i2c_sda};
            end
        end else if (prev_scl === 1'b1 && i2c_scl === 1'b0) begin
            if (s_bit == 8) begin
                s_bit = 0;
                s_byte++;
            end else begin
                s_bit++;
            end
            if (s_bit == 8 && !(s_rd && s_byte > 0)) begin
                got.push_back(s_sh);
                if (s_byte == 0) s_rd = s_sh[0];
                slv_sda = (s_byte == nack_at) ? 1'b1 : 1'b0;
            end else if (s_rd && s_byte > 0 && s_byte <= 2 && s_bit < 8) begin
                slv_sda = rd_vals[s_byte-1][7-s_bit];
            end else begin
                slv_sda = 1'b1;
            end
        end
        prev_scl  = i2c_scl;
        prev_sda  = i2c_sda;
        prev_scl2 = scl2;
    end

    task automatic wait_for(input int which, input int limit, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            case (which)
                WDone:   ok = (bus.wr_done === 1'b1);
                RDone:   ok = (bus.rd_done === 1'b1);
                Idle:    ok = (dut.state_q == 8'h01);
                InWrDat: ok = (dut.state_q == 8'h10);
                default: ok = (dut2.state_q == 8'h04);
            endcase
            if (ok) break;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    logic [7:0] wbytes[4];
    int         t[4];
    int         b_got, b_wd, b_rd, b_stop, b_mack;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wbytes       = '{8'hE8, 8'h00, 8'h00, 8'hAA};
        rd_vals[0]   = 8'h5A;
        rd_vals[1]   = 8'h3C;
        bus.wr_req   = 1'b0;
        bus.rd_req   = 1'b0;
        bus.wr_data  = 8'h00;
        bus2.wr_req  = 1'b0;
        bus2.rd_req  = 1'b0;
        bus2.wr_data = 8'h00;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // 1) idle after reset
        chk("rst_scl", {31'd0, i2c_scl}, 32'd1);
        chk("rst_is_out", {31'd0, is_out}, 32'd1);
        chk("rst_sda", {31'd0, i2c_sda}, 32'd1);
        chk("rst_state", {24'd0, dut.state_q}, 32'h01);
        chk("rst_rd_data", {24'd0, bus.rd_data}, 32'h00);
        chk("rst_wr_done_cnt", wr_done_cnt, 0);
        chk("rst_rd_done_cnt", rd_done_cnt, 0);

        // 2) four-byte write, all ACKed
        b_got  = got.size();
        b_wd   = wr_done_cnt;
        b_stop = stop_cnt;
        bus.wr_data = wbytes[0];
        bus.wr_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_for(WDone, 2500, "wr_wait_done");
            t[i] = cyc;
            if (i < 3) bus.wr_data = wbytes[i+1];
            else       bus.wr_req  = 1'b0;
        end
        chk("wr_scl_period", scl_per, 124);
        wait_for(Idle, 1000, "wr_wait_idle");
        for (int i = 1; i < 4; i++) chk("wr_done_spacing", t[i] - t[i-1], 1116);
        chk("wr_done_count", wr_done_cnt - b_wd, 4);
        chk("wr_stop_count", stop_cnt - b_stop, 1);
        chk("wr_byte_count", got.size() - b_got, 4);
        for (int i = 0; i < 4; i++) chk("wr_sda_byte", {24'd0, got[b_got+i]}, {24'd0, wbytes[i]});
        chk("wr_idle_scl", {31'd0, i2c_scl}, 32'd1);
        chk("wr_idle_sda", {31'd0, i2c_sda}, 32'd1);

        // 3) NACK on device address
        nack_at = 0;
        b_got   = got.size();
        b_wd    = wr_done_cnt;
        b_stop  = stop_cnt;
        bus.wr_data = 8'hE8;
        bus.wr_req  = 1'b1;
        @(posedge clk);
        #1 bus.wr_req = 1'b0;
        wait_for(Idle, 3000, "nack_wait_idle");
        chk("nack_wr_done", wr_done_cnt - b_wd, 0);
        chk("nack_stop", stop_cnt - b_stop, 1);
        chk("nack_bytes", got.size() - b_got, 1);
        chk("nack_addr", {24'd0, got[b_got]}, 32'hE8);
        nack_at = -1;

        // 4) register read with repeated START, two bytes
        b_got  = got.size();
        b_rd   = rd_done_cnt;
        b_stop = stop_cnt;
        b_mack = mack.size();
        bus.wr_data = 8'hE8;
        bus.rd_req  = 1'b1;
        wait_for(WDone, 2500, "rd_wait_dev");
        bus.wr_data = 8'h00;
        wait_for(WDone, 1500, "rd_wait_reg");
        wait_for(RDone, 3000, "rd_wait_b0");
        chk("rd_byte0", {24'd0, bus.rd_data}, 32'h5A);
        bus.rd_req = 1'b0;
        wait_for(RDone, 1500, "rd_wait_b1");
        chk("rd_byte1", {24'd0, bus.rd_data}, 32'h3C);
        wait_for(Idle, 1000, "rd_wait_idle");
        chk("rd_done_count", rd_done_cnt - b_rd, 2);
        chk("rd_stop", stop_cnt - b_stop, 1);
        chk("rd_addr_bytes", got.size() - b_got, 3);
        chk("rd_addr_seq", {8'd0, got[b_got], got[b_got+1], got[b_got+2]}, 32'h00E800E9);
        chk("rd_mack_count", mack.size() - b_mack, 2);
        chk("rd_mack_seq", {30'd0, mack[b_mack], mack[b_mack+1]}, 32'd1);
        chk("rd_data_held", {24'd0, bus.rd_data}, 32'h3C);

        // 5) reset in the middle of a data byte
        bus.wr_data = 8'hE8;
        bus.wr_req  = 1'b1;
        wait_for(WDone, 2500, "rst_wait_dev");
        bus.wr_data = 8'h00;
        wait_for(WDone, 1500, "rst_wait_reg");
        bus.wr_data = 8'h11;
        wait_for(InWrDat, 10, "rst_wait_wrdata");
        repeat (200) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_scl", {31'd0, i2c_scl}, 32'd1);
        chk("mid_rst_is_out", {31'd0, is_out}, 32'd1);
        chk("mid_rst_state", {24'd0, dut.state_q}, 32'h01);
        chk("mid_rst_wr_done", {31'd0, bus.wr_done}, 32'd0);
        chk("mid_rst_rd_done", {31'd0, bus.rd_done}, 32'd0);
        rst        = 1'b0;
        bus.wr_req = 1'b0;

        // 6) 100 kHz instance: SCL period of 500 clks
        bus2.wr_data = 8'hE8;
        bus2.wr_req  = 1'b1;
        wait_for(Dut2Dev, 1000, "slow_wait_dev");
        bus2.wr_req = 1'b0;
        repeat (1500) @(posedge clk);
        #1;
        chk("slow_scl_period", scl2_per, 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
